mem_stage_wb: RTL and testbench
===============================

MEM_STAGE_WB -- requirements
Module: mem_stage_wb

Interface
REQ-001 SHALL have port clk  in  1  single clock; every register updates on the rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports valid_in  in  1; rmem, wmem, wreg, VF  in  1 each  control fields from the EX/MEM register.
REQ-004 SHALL have ports dest  in  4  destination register index; alu_res  in  128  result, address = alu_res[31:0]; st_data  in  128  store data.
REQ-005 SHALL have port flush  in  1  synchronous jump-flush.
REQ-006 SHALL have port stall  out  1  hold request to upstream stages.
REQ-007 SHALL have ports mem_addr  out  32; mem_wdata  out  32; mem_re, mem_we  out  1 each; mem_rdata  in  32; mem_ready  in  1.
REQ-008 SHALL have ports wb_valid, wb_wreg, wb_VF  out  1 each; wb_dest  out  4; wb_data  out  128.

Function
REQ-009 SHALL implement a two-state FSM, IDLE and ACCESS, plus a 2-bit beat counter.
REQ-010 SHALL drive stall = (state == ACCESS); upstream holds every input stable while stall = 1.
REQ-011 SHALL accept an op in IDLE when valid_in = 1 and flush = 0.
REQ-012 SHALL handle a non-memory op (rmem = 0, wmem = 0) in 1 cycle: next edge wb_valid = 1, wb_data = alu_res, and wreg, VF and dest copied to wb_*.
REQ-013 SHALL, on accepting a memory op, latch the op and address into internal registers, with address bits [1:0] forced to 00.
REQ-014 SHALL, on accepting a memory op, set the beat count to 0, go to ACCESS, and write wb_valid = 0 (bubble).
REQ-015 SHALL, when rmem and wmem are both 1, treat the op as a store only.
REQ-016 SHALL use 4 beats when VF = 1 and 1 beat when VF = 0.
REQ-017 SHALL drive mem_addr = base + 4*beat (mod 2^32); lane i = bits [32i+31:32i].
REQ-018 SHALL assert mem_re (load) or mem_we (store) combinationally in ACCESS only, and hold both at 0 in IDLE.
REQ-019 SHALL drive mem_wdata = st_data lane[beat] for stores and 0 otherwise.
REQ-020 SHALL complete a beat only on an edge where state = ACCESS and mem_ready = 1; at that edge a load captures mem_rdata into lane[beat].
REQ-021 SHALL, when mem_ready = 0, hold the address, data and strobes with no timeout.
REQ-022 SHALL advance beat on a non-final beat completion.
REQ-023 SHALL, on final beat completion, go to IDLE at that edge and write wb_valid = 1, wb_wreg, wb_VF and wb_dest.
REQ-024 SHALL set wb_data on final completion: vector load = the 4 assembled lanes; scalar load = {96'h0, mem_rdata}; store = 0.
REQ-025 SHALL make stall fall in the cycle after the final beat, so a new op is accepted 1 cycle later.
REQ-026 SHALL write wb_valid = 0 and hold the other wb_* outputs in every cycle that produces no result: idle with valid_in = 0, ACCESS non-final cycles.
REQ-027 SHALL give flush priority over all other events.
REQ-028 SHALL, when flush = 1 in IDLE, accept no op; next edge wb_valid = 0.
REQ-029 SHALL, when flush = 1 in ACCESS, abort: next edge IDLE, beat = 0, wb_valid = 0, no writeback, even if mem_ready = 1 in that cycle.
REQ-030 SHALL leave store beats that completed before a flush in memory, with no rollback.

Reset
REQ-031 SHALL, while rst = 0, asynchronously force state = IDLE, beat = 0, latched op and data = 0, and all wb_* = 0.
REQ-032 SHALL, while rst = 0, force stall, mem_re and mem_we to 0; mem_addr and mem_wdata = 0.
REQ-033 SHALL, if rst falls mid-access, abandon the access without writeback; the first op is accepted on the first edge with rst = 1.

Verification
REQ-034 SHALL cover ALU op: alu_res = 128'hA5..A5, wreg = 1, dest = 3 -> next cycle wb_valid = 1, wb_data = A5..A5, wb_dest = 3, stall = 0 throughout.
REQ-035 SHALL cover vector load: addr = 0x100, VF = 1, mem_ready = 1 always, mem_rdata = 0x11, 0x22, 0x33, 0x44 -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C; stall high 4 cycles; wb_data = {0x44, 0x33, 0x22, 0x11}.
REQ-036 SHALL cover wait states on a scalar store: addr = 0x203, mem_ready low 3 cycles then high -> mem_addr = 0x200 and mem_we held 4 cycles; wb_valid = 1 with wb_data = 0 one edge later.
REQ-037 SHALL cover wrap-around: vector store at 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-038 SHALL cover flush mid-access: flush = 1 during beat 2 of a vector load with mem_ready = 1 -> next edge IDLE, stall = 0, wb_valid stays 0.
REQ-039 SHALL cover reset mid-access: rst = 0 during beat 1 -> immediate stall = 0, mem_re = 0, wb_* = 0; an op issued after release completes normally.

Source files
------------

// File: rtl/mem_stage_wb.sv
// -----------------------------------------------------------------------------
// mem_stage_wb -- memory stage with writeback register for a SIMD pipeline.
//
// Takes one operation from the EX/MEM register and either passes an ALU result
// straight through to writeback (one cycle) or runs a memory access of one
// beat (scalar) or four beats (vector, 4 x 32-bit lanes) over a simple
// request/ready memory port. While an access is in flight, stall holds the
// upstream stages. A jump flush aborts the current access without writeback.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active low
//   valid_in   in   1    operation present on the EX/MEM fields below
//   rmem/wmem  in   1    load / store request (both set -> store)
//   wreg       in   1    operation writes the register file
//   VF         in   1    vector flag: 4 beats when set, 1 beat otherwise
//   dest       in   4    destination register index
//   alu_res    in   128  ALU result; bits [31:0] are the memory address
//   st_data    in   128  store data, lane i = bits [32i+31:32i]
//   flush      in   1    synchronous jump flush, highest priority
//   stall      out  1    hold request to upstream stages (high in ACCESS)
//   mem_addr   out  32   word address of the current beat
//   mem_wdata  out  32   store lane of the current beat, 0 for loads
//   mem_re     out  1    load strobe (ACCESS only)
//   mem_we     out  1    store strobe (ACCESS only)
//   mem_rdata  in   32   load data, sampled when mem_ready is high
//   mem_ready  in   1    current beat completes on this edge
//   wb_valid   out  1    writeback result valid for one cycle
//   wb_wreg    out  1    writeback register-write enable
//   wb_VF      out  1    writeback vector flag
//   wb_dest    out  4    writeback destination index
//   wb_data    out  128  writeback data
// -----------------------------------------------------------------------------
module mem_stage_wb (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         rmem,
  input  logic         wmem,
  input  logic         wreg,
  input  logic         VF,
  input  logic [3:0]   dest,
  input  logic [127:0] alu_res,
  input  logic [127:0] st_data,
  input  logic         flush,
  output logic         stall,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         mem_re,
  output logic         mem_we,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic         wb_valid,
  output logic         wb_wreg,
  output logic         wb_VF,
  output logic [3:0]   wb_dest,
  output logic [127:0] wb_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Beat counter and the operation latched at acceptance.
  logic [1:0]   r_beat;
  logic         r_is_store;
  logic         r_is_vec;
  logic         r_wreg;
  logic [3:0]   r_dest;
  logic [31:0]  r_base;
  logic [127:0] r_st_data;
  // Lanes 0..2 of a vector load; lane 3 is taken straight from mem_rdata on
  // the final beat, so it never needs its own register.
  logic [95:0]  r_ld_lanes;

  logic         w_accept;
  logic         w_is_mem_op;
  logic         w_last_beat;
  logic         w_beat_done;
  logic         w_final;
  logic [31:0]  w_st_lane;
  logic [127:0] w_final_data;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_accept    = (r_state == IDLE) && valid_in && !flush;
  assign w_is_mem_op = rmem || wmem;
  assign w_last_beat = r_is_vec ? (r_beat == 2'd3) : (r_beat == 2'd0);
  // Flush wins over a completing beat, so a flushed cycle never counts.
  assign w_beat_done = (r_state == ACCESS) && mem_ready && !flush;
  assign w_final     = w_beat_done && w_last_beat;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem_op) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (flush || w_final) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (memory port and stall)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_st_lane = 32'h0;
    unique case (r_beat)
      2'd0: w_st_lane = r_st_data[31:0];
      2'd1: w_st_lane = r_st_data[63:32];
      2'd2: w_st_lane = r_st_data[95:64];
      2'd3: w_st_lane = r_st_data[127:96];
      default: w_st_lane = 32'h0;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    // Address wraps modulo 2^32; base is 0 out of reset so this reads 0 then.
    mem_addr  = r_base + {28'h0, r_beat, 2'b00};
    if (r_state == ACCESS) begin
      stall  = 1'b1;
      mem_re = !r_is_store;
      mem_we = r_is_store;
      if (r_is_store) begin
        mem_wdata = w_st_lane;
      end
    end
  end

  // Result written back on the final beat of a memory op.
  always_comb begin
    w_final_data = 128'h0;
    if (!r_is_store) begin
      if (r_is_vec) begin
        w_final_data = {mem_rdata, r_ld_lanes};
      end else begin
        w_final_data = {96'h0, mem_rdata};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched operation, beat counter, load lanes, writeback register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat     <= 2'd0;
      r_is_store <= 1'b0;
      r_is_vec   <= 1'b0;
      r_wreg     <= 1'b0;
      r_dest     <= 4'h0;
      r_base     <= 32'h0;
      r_st_data  <= 128'h0;
      r_ld_lanes <= 96'h0;
      wb_valid   <= 1'b0;
      wb_wreg    <= 1'b0;
      wb_VF      <= 1'b0;
      wb_dest    <= 4'h0;
      wb_data    <= 128'h0;
    end else begin
      // Default: no result this cycle; other wb_* fields hold.
      wb_valid <= 1'b0;

      if (w_accept) begin
        if (w_is_mem_op) begin
          // A request with both rmem and wmem set is handled as a store.
          r_is_store <= wmem;
          r_is_vec   <= VF;
          r_wreg     <= wreg;
          r_dest     <= dest;
          r_base     <= {alu_res[31:2], 2'b00};
          r_st_data  <= st_data;
          r_beat     <= 2'd0;
        end else begin
          wb_valid <= 1'b1;
          wb_data  <= alu_res;
          wb_wreg  <= wreg;
          wb_VF    <= VF;
          wb_dest  <= dest;
        end
      end else if (r_state == ACCESS) begin
        if (flush) begin
          // Abort: completed store beats stay in memory, nothing written back.
          r_beat <= 2'd0;
        end else if (w_beat_done) begin
          if (!r_is_store) begin
            unique case (r_beat)
              2'd0: r_ld_lanes[31:0]  <= mem_rdata;
              2'd1: r_ld_lanes[63:32] <= mem_rdata;
              2'd2: r_ld_lanes[95:64] <= mem_rdata;
              default: ;
            endcase
          end
          if (w_last_beat) begin
            r_beat   <= 2'd0;
            wb_valid <= 1'b1;
            wb_data  <= w_final_data;
            wb_wreg  <= r_wreg;
            wb_VF    <= r_is_vec;
            wb_dest  <= r_dest;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_wb -- directed self-checking bench for mem_stage_wb.
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled at that point, combinational outputs one more unit later.
// -----------------------------------------------------------------------------
module tb_mem_stage_wb;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic         rmem;
  logic         wmem;
  logic         wreg;
  logic         VF;
  logic [3:0]   dest;
  logic [127:0] alu_res;
  logic [127:0] st_data;
  logic         flush;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_re;
  logic         mem_we;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         wb_valid;
  logic         wb_wreg;
  logic         wb_VF;
  logic [3:0]   wb_dest;
  logic [127:0] wb_data;

  int errors = 0;
  int checks = 0;

  mem_stage_wb dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .rmem      (rmem),
    .wmem      (wmem),
    .wreg      (wreg),
    .VF        (VF),
    .dest      (dest),
    .alu_res   (alu_res),
    .st_data   (st_data),
    .flush     (flush),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .wb_valid  (wb_valid),
    .wb_wreg   (wb_wreg),
    .wb_VF     (wb_VF),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; rmem = 1'b0; wmem = 1'b0; wreg = 1'b0;
    VF = 1'b0; dest = 4'h0; alu_res = '0; st_data = '0; flush = 1'b0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL reset_strobes: stall=%b re=%b we=%b, want 0 0 0", stall, mem_re, mem_we);
    else checks += 0;
    if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) errors++;
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_VF !== 1'b0 || wb_dest !== 4'h0 || wb_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_wb: valid=%b wreg=%b vf=%b dest=%h data=%h, want all 0",
               wb_valid, wb_wreg, wb_VF, wb_dest, wb_data);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_op();
    valid_in = 1'b1; rmem = 1'b0; wmem = 1'b0; wreg = 1'b1; VF = 1'b0;
    dest = 4'd3; alu_res = {16{8'hA5}};
    settle();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall_pre: stall=%b, want 0", stall);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== {16{8'hA5}} || wb_dest !== 4'd3 || wb_wreg !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_wb: valid=%b data=%h dest=%0d wreg=%b stall=%b, want 1 A5..A5 3 1 0",
               wb_valid, wb_data, wb_dest, wb_wreg, stall);
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== {16{8'hA5}} || wb_dest !== 4'd3) begin
      errors++;
      $display("FAIL alu_idle_hold: valid=%b data=%h dest=%0d, want 0 A5..A5 3", wb_valid, wb_data, wb_dest);
    end
  endtask

  task automatic test_vector_load();
    logic [31:0] rdata [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int stall_cycles = 0;
    valid_in = 1'b1; rmem = 1'b1; wmem = 1'b0; wreg = 1'b1; VF = 1'b1;
    dest = 4'd5; alu_res = {96'h0, 32'h0000_0100}; mem_ready = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL vload_accept: wb_valid=%b stall=%b, want 0 1", wb_valid, stall);
    end
    for (int b = 0; b < 4; b++) begin
      mem_rdata = rdata[b];
      settle();
      if (stall === 1'b1) stall_cycles++;
      checks++;
      if (mem_addr !== 32'h100 + 32'(4 * b) || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
        errors++;
        $display("FAIL vload_beat%0d: addr=%h re=%b we=%b wdata=%h, want %h 1 0 0",
                 b, mem_addr, mem_re, mem_we, mem_wdata, 32'h100 + 32'(4 * b));
      end
      tick();
      if (b < 3) begin
        checks++;
        if (wb_valid !== 1'b0) begin
          errors++;
          $display("FAIL vload_bubble%0d: wb_valid=%b, want 0", b, wb_valid);
        end
      end
    end
    valid_in = 1'b0; rmem = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== {32'h44, 32'h33, 32'h22, 32'h11} || wb_dest !== 4'd5
        || wb_VF !== 1'b1 || wb_wreg !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL vload_wb: valid=%b data=%h dest=%0d vf=%b wreg=%b stall=%b, want 1 44_33_22_11 5 1 1 0",
               wb_valid, wb_data, wb_dest, wb_VF, wb_wreg, stall);
    end
    checks++;
    if (stall_cycles != 4) begin
      errors++;
      $display("FAIL vload_stall_len: stall cycles=%0d, want 4", stall_cycles);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL vload_after: wb_valid=%b re=%b, want 0 0", wb_valid, mem_re);
    end
  endtask

  // rmem and wmem both set: must behave as a store only.
  task automatic test_store_wait();
    int we_cycles = 0;
    valid_in = 1'b1; rmem = 1'b1; wmem = 1'b1; wreg = 1'b0; VF = 1'b0;
    dest = 4'd7; alu_res = {96'h0, 32'h0000_0203};
    st_data = {32'h4, 32'h3, 32'h2, 32'hDEAD_BEEF}; mem_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      settle();
      if (mem_we === 1'b1) we_cycles++;
      checks++;
      if (mem_addr !== 32'h200 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL store_wait%0d: addr=%h we=%b re=%b wdata=%h, want 200 1 0 deadbeef",
                 c, mem_addr, mem_we, mem_re, mem_wdata);
      end
      tick();
      if (c < 3) begin
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b1) begin
          errors++;
          $display("FAIL store_hold%0d: wb_valid=%b stall=%b, want 0 1", c, wb_valid, stall);
        end
      end
    end
    valid_in = 1'b0; rmem = 1'b0; wmem = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 128'h0 || wb_dest !== 4'd7 || wb_wreg !== 1'b0 || wb_VF !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL store_wb: valid=%b data=%h dest=%0d wreg=%b vf=%b stall=%b, want 1 0 7 0 0 0",
               wb_valid, wb_data, wb_dest, wb_wreg, wb_VF, stall);
    end
    checks++;
    if (we_cycles != 4) begin
      errors++;
      $display("FAIL store_we_len: mem_we cycles=%0d, want 4", we_cycles);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] lanes [4] = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    valid_in = 1'b1; rmem = 1'b0; wmem = 1'b1; wreg = 1'b0; VF = 1'b1;
    dest = 4'd8; alu_res = {96'h0, 32'hFFFF_FFF8};
    st_data = {32'hD4, 32'hC3, 32'hB2, 32'hA1}; mem_ready = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      settle();
      checks++;
      if (mem_addr !== addrs[b] || mem_wdata !== lanes[b] || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr=%h wdata=%h we=%b, want %h %h 1",
                 b, mem_addr, mem_wdata, mem_we, addrs[b], lanes[b]);
      end
      tick();
    end
    valid_in = 1'b0; wmem = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 128'h0 || wb_VF !== 1'b1 || wb_dest !== 4'd8 || stall !== 1'b0) begin
      errors++;
      $display("FAIL wrap_wb: valid=%b data=%h vf=%b dest=%0d stall=%b, want 1 0 1 8 0",
               wb_valid, wb_data, wb_VF, wb_dest, stall);
    end
    tick();
  endtask

  task automatic test_flush();
    valid_in = 1'b1; rmem = 1'b1; wmem = 1'b0; wreg = 1'b1; VF = 1'b1;
    dest = 4'd6; alu_res = {96'h0, 32'h0000_0300}; mem_ready = 1'b1;
    mem_rdata = 32'h9999_0000;
    tick();
    tick();
    tick();
    flush = 1'b1;
    settle();
    checks++;
    if (mem_addr !== 32'h308 || mem_re !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_beat2: addr=%h re=%b stall=%b, want 308 1 1", mem_addr, mem_re, stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || mem_re !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 128'h0 || wb_dest !== 4'd8) begin
      errors++;
      $display("FAIL flush_abort: stall=%b re=%b wb_valid=%b data=%h dest=%0d, want 0 0 0 0 8",
               stall, mem_re, wb_valid, wb_data, wb_dest);
    end
    // Flush in IDLE blocks acceptance of an ALU op.
    rmem = 1'b0; VF = 1'b0; dest = 4'd10; alu_res = {4{32'h0BAD_F00D}};
    tick();
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b0 || wb_dest !== 4'd8) begin
      errors++;
      $display("FAIL flush_idle: wb_valid=%b stall=%b dest=%0d, want 0 0 8", wb_valid, stall, wb_dest);
    end
    flush = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== {4{32'h0BAD_F00D}} || wb_dest !== 4'd10) begin
      errors++;
      $display("FAIL flush_release: wb_valid=%b data=%h dest=%0d, want 1 0badf00d x4 10",
               wb_valid, wb_data, wb_dest);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; rmem = 1'b1; wmem = 1'b0; wreg = 1'b1; VF = 1'b0;
    dest = 4'd9; alu_res = {96'h0, 32'h0000_0041}; mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    settle();
    checks++;
    if (mem_addr !== 32'h40 || mem_re !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load_req: addr=%h re=%b stall=%b, want 40 1 1", mem_addr, mem_re, stall);
    end
    tick();
    rmem = 1'b0; dest = 4'd2; alu_res = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== {96'h0, 32'hCAFE_F00D} || wb_dest !== 4'd9 || wb_VF !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_scalar_wb: valid=%b data=%h dest=%0d vf=%b stall=%b, want 1 cafef00d 9 0 0",
               wb_valid, wb_data, wb_dest, wb_VF, stall);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321 || wb_dest !== 4'd2) begin
      errors++;
      $display("FAIL b2b_alu_wb: valid=%b data=%h dest=%0d, want 1 12345678.. 2", wb_valid, wb_data, wb_dest);
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: wb_valid=%b, want 0", wb_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    valid_in = 1'b1; rmem = 1'b1; wmem = 1'b0; wreg = 1'b1; VF = 1'b1;
    dest = 4'd12; alu_res = {96'h0, 32'h0000_0500}; mem_ready = 1'b1;
    mem_rdata = 32'h55;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_bus: stall=%b re=%b we=%b addr=%h wdata=%h, want 0 0 0 0 0",
               stall, mem_re, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 128'h0 || wb_dest !== 4'h0 || wb_wreg !== 1'b0 || wb_VF !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wb: valid=%b data=%h dest=%0d wreg=%b vf=%b, want all 0",
               wb_valid, wb_data, wb_dest, wb_wreg, wb_VF);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_held: stall=%b wb_valid=%b, want 0 0", stall, wb_valid);
    end
    @(negedge clk);
    VF = 1'b0; dest = 4'd1; alu_res = {96'h0, 32'h0000_0600}; mem_rdata = 32'h77;
    rst = 1'b1;
    tick();
    settle();
    checks++;
    if (mem_addr !== 32'h600 || mem_re !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_new_req: addr=%h re=%b stall=%b, want 600 1 1", mem_addr, mem_re, stall);
    end
    tick();
    valid_in = 1'b0; rmem = 1'b0;
    settle();
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== {96'h0, 32'h77} || wb_dest !== 4'd1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_new_wb: valid=%b data=%h dest=%0d stall=%b, want 1 77 1 0",
               wb_valid, wb_data, wb_dest, stall);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_vector_load();
    test_store_wait();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
